control_unit: RTL

//  Moore-FSM control unit for the single-bus 32-bit datapath. Generates every
//  bus-drive, register-load, ALU-op and memory strobe per step.

---
 rtl/control_unit_if.sv | 31 +++
 rtl/control_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// Control-unit boundary: instruction/memory-handshake inputs plus every
// datapath strobe. master = control unit, slave = datapath/memory side.
interface control_unit_if;
  logic [31:0] IR;
  logic        mem_rdy;
  logic        step;

  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, BAout;
  logic Gra, Grb, Grc, Rin, Rout;
  logic PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin;
  logic AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC;
  logic read, mem_write, run, fault;

  modport master (
    input  IR, mem_rdy, step,
    output PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, BAout,
    output Gra, Grb, Grc, Rin, Rout,
    output PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin,
    output AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
    output read, mem_write, run, fault
  );

  modport slave (
    output IR, mem_rdy, step,
    input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, BAout,
    input  Gra, Grb, Grc, Rin, Rout,
    input  PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin,
    input  AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT, IncPC,
    input  read, mem_write, run, fault
  );
endinterface

// File: rtl/control_unit.sv
// Moore-FSM control unit for the single-bus 32-bit datapath (fetch/decode/execute,
// memory wait states with timeout). Optional single-step gating: define CU_STEP_EN.
module control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int OPW         = 5
) (
  input  logic           clk,
  input  logic           clear,
  control_unit_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01101);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_DEC,
    S_RT3, S_RT4, S_IT4, S_RT5,
    S_UT3, S_UT4,
    S_MT3, S_MT4, S_MT5, S_MT6,
    S_LT3, S_LT4, S_LT5, S_LT6, S_LT7,
    S_ST6, S_ST7,
    S_HALT, S_FAULT
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0] op_q, op_d;
  logic [OPW-1:0] opcode;
  logic           step_go;
  logic           in_wait;
  state_t         wait_tgt;
  logic           alu_sel;
  logic           unused_ok;

  assign opcode    = bus.IR[31 -: OPW];
  assign unused_ok = ^{bus.IR[31-OPW:0], bus.step};

`ifdef CU_STEP_EN
  assign step_go = bus.step;
`else
  assign step_go = 1'b1;
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= S_F0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    in_wait  = 1'b0;
    wait_tgt = state_q;
    case (state_q)
      S_F0:  if (step_go) state_d = S_F1;
      S_F1:  begin in_wait = 1'b1; wait_tgt = S_F2; end
      S_F2:  state_d = S_DEC;
      S_DEC: begin
        // opcode is captured here so execute steps do not depend on IR staying put
        op_d = opcode;
        case (opcode)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: state_d = S_RT3;
          OP_NEG, OP_NOT:                          state_d = S_UT3;
          OP_MUL, OP_DIV:                          state_d = S_MT3;
          OP_LD, OP_ST:                            state_d = S_LT3;
          OP_HALT:                                 state_d = S_HALT;
          default:                                 state_d = S_F0;
        endcase
      end
      S_RT3: state_d = (op_q == OP_ADDI || op_q == OP_ANDI || op_q == OP_ORI) ? S_IT4 : S_RT4;
      S_RT4, S_IT4: state_d = S_RT5;
      S_RT5: state_d = S_F0;
      S_UT3: state_d = S_UT4;
      S_UT4: state_d = S_F0;
      S_MT3: state_d = S_MT4;
      S_MT4: state_d = S_MT5;
      S_MT5: state_d = S_MT6;
      S_MT6: state_d = S_F0;
      S_LT3: state_d = S_LT4;
      S_LT4: state_d = S_LT5;
      S_LT5: state_d = (op_q == OP_ST) ? S_ST6 : S_LT6;
      S_LT6: begin in_wait = 1'b1; wait_tgt = S_LT7; end
      S_LT7: state_d = S_F0;
      S_ST6: state_d = S_ST7;
      S_ST7: begin in_wait = 1'b1; wait_tgt = S_F0; end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_F0;
    endcase

    // Shared memory-wait handling: advance on ready, otherwise count toward timeout.
    if (in_wait) begin
      if (bus.mem_rdy) begin
        state_d = wait_tgt;
        cnt_d   = '0;
      end else if (cnt_q == CW'(MEM_TIMEOUT)) begin
        state_d = S_FAULT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin : out_decode
    bus.PCout = 1'b0; bus.MDRout = 1'b0; bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
    bus.HIout = 1'b0; bus.LOout  = 1'b0; bus.Cout     = 1'b0; bus.BAout   = 1'b0;
    bus.Gra   = 1'b0; bus.Grb    = 1'b0; bus.Grc      = 1'b0; bus.Rin     = 1'b0;
    bus.Rout  = 1'b0;
    bus.PCin  = 1'b0; bus.IRin   = 1'b0; bus.MARin    = 1'b0; bus.Yin     = 1'b0;
    bus.HIin  = 1'b0; bus.LOin   = 1'b0; bus.Zin      = 1'b0; bus.MDRin   = 1'b0;
    bus.AND   = 1'b0; bus.OR     = 1'b0; bus.ADD      = 1'b0; bus.SUB     = 1'b0;
    bus.MUL   = 1'b0; bus.DIV    = 1'b0; bus.SHR      = 1'b0; bus.SHL     = 1'b0;
    bus.ROR   = 1'b0; bus.ROL    = 1'b0; bus.NEG      = 1'b0; bus.NOT     = 1'b0;
    bus.IncPC = 1'b0;
    bus.read  = 1'b0; bus.mem_write = 1'b0; bus.run = 1'b0; bus.fault = 1'b0;
    alu_sel   = 1'b0;

    // clear forces every strobe low immediately, independent of the clock
    if (clear) begin
      case (state_q)
        S_F0: if (step_go) begin
          bus.run = 1'b1; bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
        end
        S_F1:  begin bus.run = 1'b1; bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1; end
        S_F2:  begin bus.run = 1'b1; bus.MDRout = 1'b1; bus.IRin = 1'b1; end
        S_DEC: bus.run = 1'b1;
        S_RT3: begin bus.run = 1'b1; bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
        S_RT4: begin bus.run = 1'b1; bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; alu_sel = 1'b1; end
        S_IT4: begin bus.run = 1'b1; bus.Cout = 1'b1; bus.Zin = 1'b1; alu_sel = 1'b1; end
        S_RT5, S_UT4: begin bus.run = 1'b1; bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        S_UT3: begin bus.run = 1'b1; bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; alu_sel = 1'b1; end
        S_MT3: begin bus.run = 1'b1; bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
        S_MT4: begin bus.run = 1'b1; bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; alu_sel = 1'b1; end
        S_MT5: begin bus.run = 1'b1; bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
        S_MT6: begin bus.run = 1'b1; bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
        S_LT3: begin bus.run = 1'b1; bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
        S_LT4: begin bus.run = 1'b1; bus.Cout = 1'b1; bus.ADD = 1'b1; bus.Zin = 1'b1; end
        S_LT5: begin bus.run = 1'b1; bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
        S_LT6: begin bus.run = 1'b1; bus.read = 1'b1; bus.MDRin = 1'b1; end
        S_LT7: begin bus.run = 1'b1; bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        S_ST6: begin bus.run = 1'b1; bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
        S_ST7: begin bus.run = 1'b1; bus.mem_write = 1'b1; end
        S_FAULT: bus.fault = 1'b1;
        default: ;
      endcase
    end

    if (alu_sel) begin
      case (op_q)
        OP_ADD, OP_ADDI: bus.ADD = 1'b1;
        OP_SUB:          bus.SUB = 1'b1;
        OP_SHR:          bus.SHR = 1'b1;
        OP_SHL:          bus.SHL = 1'b1;
        OP_ROR:          bus.ROR = 1'b1;
        OP_ROL:          bus.ROL = 1'b1;
        OP_AND, OP_ANDI: bus.AND = 1'b1;
        OP_OR, OP_ORI:   bus.OR  = 1'b1;
        OP_MUL:          bus.MUL = 1'b1;
        OP_DIV:          bus.DIV = 1'b1;
        OP_NEG:          bus.NEG = 1'b1;
        OP_NOT:          bus.NOT = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
